gpio_in_capture: RTL and testbench



---
 rtl/gpio_pkg.sv | 9 +
 rtl/gpio_debounce_bit.sv | 45 ++++
 rtl/gpio_in_capture.sv | 64 ++++++
 tb/tb_gpio_in_capture.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO input peripheral: register map and bus width.
package gpio_pkg;
    localparam int BUS_W = 32;

    localparam logic [1:0] GPIO_IN_STATE = 2'd0;
    localparam logic [1:0] GPIO_IN_RISE  = 2'd1;
    localparam logic [1:0] GPIO_IN_FALL  = 2'd2;
    localparam logic [1:0] GPIO_IN_IRQEN = 2'd3;
endpackage

// File: rtl/gpio_debounce_bit.sv
// One input pin: 2-flop synchronizer, persistence counter, debounced level,
// and one-cycle rise/fall indications aligned with the edge that updates stable.
module gpio_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic stable,
    output logic rise_set,
    output logic fall_set
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1, sync2;
    logic [CW-1:0] cnt;
    logic          accept;

    // The new level has persisted long enough; stable takes it on this edge.
    assign accept   = (sync2 != stable) && (cnt == CNT_MAX);
    assign rise_set = accept &  sync2;
    assign fall_set = accept & ~sync2;

    // Synchronize, then count consecutive cycles the synchronized level differs from stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/gpio_in_capture.sv
// Memory-mapped GPIO input port: debounced pin state, sticky W1C edge flags,
// interrupt enables and a level interrupt for enabled edges.
module gpio_in_capture
    import gpio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       addr,
    input  logic [BUS_W-1:0] DataToIn,
    input  logic [WIDTH-1:0] PORT_IN,
    output logic [BUS_W-1:0] DataFromIn,
    output logic             irq
);
    logic [WIDTH-1:0] stable, rise_set, fall_set;
    logic [WIDTH-1:0] rise, fall, irq_en;
    logic [WIDTH-1:0] rise_clr, fall_clr;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpio_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk     (clk),
            .rst     (rst),
            .pin     (PORT_IN[i]),
            .stable  (stable[i]),
            .rise_set(rise_set[i]),
            .fall_set(fall_set[i])
        );
    end

    assign rise_clr = (en && addr == GPIO_IN_RISE) ? DataToIn[WIDTH-1:0] : '0;
    assign fall_clr = (en && addr == GPIO_IN_FALL) ? DataToIn[WIDTH-1:0] : '0;

    // Sticky edge flags; a new edge outranks a W1C landing on the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise   <= '0;
            fall   <= '0;
            irq_en <= '0;
        end else begin
            rise <= (rise & ~rise_clr) | rise_set;
            fall <= (fall & ~fall_clr) | fall_set;
            if (en && addr == GPIO_IN_IRQEN)
                irq_en <= DataToIn[WIDTH-1:0];
        end
    end

    // Read mux; unused upper bits read as zero.
    always_comb begin
        DataFromIn = '0;
        case (addr)
            GPIO_IN_STATE: DataFromIn[WIDTH-1:0] = stable;
            GPIO_IN_RISE:  DataFromIn[WIDTH-1:0] = rise;
            GPIO_IN_FALL:  DataFromIn[WIDTH-1:0] = fall;
            default:       DataFromIn[WIDTH-1:0] = irq_en;
        endcase
    end

    assign irq = |((rise | fall) & irq_en);
endmodule

// File: tb/tb_gpio_in_capture.sv
// Self-checking bench for gpio_in_capture with WIDTH=8, DEBOUNCE_CYCLES=4.
module tb_gpio_in_capture;
    localparam int W = 8;
    localparam int D = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic [1:0]    addr = 2'd0;
    logic [31:0]   DataToIn = '0;
    logic [W-1:0]  PORT_IN = '0;
    logic [31:0]   DataFromIn;
    logic          irq;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    gpio_in_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .en(en), .addr(addr), .DataToIn(DataToIn),
        .PORT_IN(PORT_IN), .DataFromIn(DataFromIn), .irq(irq)
    );

    // Reference model: stable flips once the last D synchronized samples all
    // disagree with it; pins reach the synchronized view two edges late.
    logic [W-1:0] m_s1, m_s2, m_stable, m_rise, m_fall, m_en;
    logic [W-1:0] m_hist [D];

    always @(posedge clk or posedge rst) begin : model
        logic [W-1:0] flip, clr_r, clr_f;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0;
            m_rise = '0; m_fall = '0; m_en = '0;
            for (int j = 0; j < D; j++) m_hist[j] = '0;
        end else begin
            for (int j = D - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = m_s2;
            flip = '1;
            for (int j = 0; j < D; j++) flip &= (m_hist[j] ^ m_stable);
            clr_r = (en && addr == 2'd1) ? DataToIn[W-1:0] : '0;
            clr_f = (en && addr == 2'd2) ? DataToIn[W-1:0] : '0;
            m_rise = (m_rise & ~clr_r) | (flip & ~m_stable);
            m_fall = (m_fall & ~clr_f) | (flip &  m_stable);
            if (en && addr == 2'd3) m_en = DataToIn[W-1:0];
            m_stable = m_stable ^ flip;
            m_s2 = m_s1;
            m_s1 = PORT_IN;
        end
    end

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_stable);
            2'd1:    return 32'(m_rise);
            2'd2:    return 32'(m_fall);
            default: return 32'(m_en);
        endcase
    endfunction

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        en = 1'b1; addr = a; DataToIn = d;
        @(negedge clk);
        en = 1'b0; DataToIn = '0;
    endtask

    task automatic clear_all();
        wr(2'd1, 32'hFFFF_FFFF);
        wr(2'd2, 32'hFFFF_FFFF);
        wr(2'd3, 32'h0);
    endtask

    task automatic settle_low();
        @(negedge clk);
        PORT_IN = '0;
        repeat (2 + D + 2) @(negedge clk);
        clear_all();
    endtask

    task automatic test_reset();
        en = 1'b0; addr = 2'd0; DataToIn = '0; PORT_IN = '0;
        #2 rst = 1'b1;
        #10;
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a); #1;
            vectors++;
            if (DataFromIn !== 32'h0) begin
                errors++; $display("FAIL reset_reg%0d: got %h expected 0", a, DataFromIn);
            end
        end
        vectors++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
        @(negedge clk) rst = 1'b0;
        repeat (50) begin
            @(negedge clk);
            for (int a = 0; a < 4; a++) begin
                addr = 2'(a); #1;
                vectors++;
                if (DataFromIn !== 32'h0) begin
                    errors++; $display("FAIL idle_reg%0d: got %h expected 0", a, DataFromIn);
                end
            end
            vectors++;
            if (irq !== 1'b0) begin errors++; $display("FAIL idle_irq: got %b expected 0", irq); end
        end
    endtask

    task automatic test_debounce_edge();
        settle_low();
        PORT_IN = 8'h01; addr = 2'd0;
        for (int n = 1; n <= 2 + D; n++) begin
            @(negedge clk); #1;
            vectors++;
            if (DataFromIn !== ((n >= 2 + D) ? 32'h1 : 32'h0)) begin
                errors++; $display("FAIL latency_n%0d: got %h expected %h", n, DataFromIn,
                                   (n >= 2 + D) ? 32'h1 : 32'h0);
            end
        end
        addr = 2'd1; #1; vectors++;
        if (DataFromIn !== 32'h01) begin errors++; $display("FAIL rise_after_edge: got %h expected 01", DataFromIn); end
        addr = 2'd2; #1; vectors++;
        if (DataFromIn !== 32'h00) begin errors++; $display("FAIL fall_after_rise: got %h expected 00", DataFromIn); end
    endtask

    task automatic test_glitch();
        clear_all();
        PORT_IN = 8'h81;
        repeat (D - 1) @(negedge clk);
        PORT_IN = 8'h01;
        repeat (12) begin
            @(negedge clk);
            addr = 2'd0; #1; vectors++;
            if (DataFromIn !== 32'h01) begin errors++; $display("FAIL glitch_state: got %h expected 01", DataFromIn); end
            addr = 2'd1; #1; vectors++;
            if (DataFromIn !== 32'h00) begin errors++; $display("FAIL glitch_rise: got %h expected 00", DataFromIn); end
        end
    endtask

    task automatic test_irq();
        settle_low();
        wr(2'd3, 32'h01);
        addr = 2'd0; #1; vectors++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b expected 0", irq); end
        PORT_IN = 8'h01;
        repeat (2 + D) @(negedge clk);
        #1; vectors++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_on_rise: got %b expected 1", irq); end
        wr(2'd1, 32'h01);
        addr = 2'd1; #1; vectors++;
        if (DataFromIn !== 32'h0 || irq !== 1'b0) begin
            errors++; $display("FAIL w1c_rise: got rise=%h irq=%b expected 0/0", DataFromIn, irq);
        end
        wr(2'd1, 32'h02);
        addr = 2'd1; #1; vectors++;
        if (DataFromIn !== 32'h0 || irq !== 1'b0) begin
            errors++; $display("FAIL w1c_clear_bit: got rise=%h irq=%b expected 0/0", DataFromIn, irq);
        end
        PORT_IN = 8'h00;
        repeat (2 + D) @(negedge clk);
        #1; vectors++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_on_fall: got %b expected 1", irq); end
        wr(2'd3, 32'h0);
        addr = 2'd2; #1; vectors++;
        if (irq !== 1'b0 || DataFromIn !== 32'h01) begin
            errors++; $display("FAIL irq_disable: got irq=%b fall=%h expected 0/01", irq, DataFromIn);
        end
    endtask

    task automatic test_set_wins();
        settle_low();
        PORT_IN = 8'h08;
        repeat (D) @(negedge clk);
        wr(2'd1, 32'h08);
        addr = 2'd1; #1; vectors++;
        if (DataFromIn !== 32'h08) begin errors++; $display("FAIL set_wins_rise: got %h expected 08", DataFromIn); end
        addr = 2'd0; #1; vectors++;
        if (DataFromIn !== 32'h08) begin errors++; $display("FAIL set_wins_state: got %h expected 08", DataFromIn); end
    endtask

    task automatic test_reset_mid();
        settle_low();
        wr(2'd3, 32'hFF);
        PORT_IN = 8'h01;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a); #1; vectors++;
            if (DataFromIn !== 32'h0) begin
                errors++; $display("FAIL midreset_reg%0d: got %h expected 0", a, DataFromIn);
            end
        end
        @(negedge clk) rst = 1'b0;
        addr = 2'd0;
        for (int n = 1; n <= 2 + D; n++) begin
            @(negedge clk); #1; vectors++;
            if (DataFromIn !== ((n == 2 + D) ? 32'h1 : 32'h0)) begin
                errors++; $display("FAIL post_reset_n%0d: got %h expected %h", n, DataFromIn,
                                   (n == 2 + D) ? 32'h1 : 32'h0);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) PORT_IN = PORT_IN ^ W'($urandom);
            en       = ($urandom_range(0, 5) == 0);
            addr     = 2'($urandom);
            DataToIn = $urandom;
            #1; vectors++;
            if (DataFromIn !== m_read(addr) || irq !== (|((m_rise | m_fall) & m_en))) begin
                errors++;
                $display("FAIL random_c%0d addr%0d: got %h irq=%b expected %h irq=%b", c, addr,
                         DataFromIn, irq, m_read(addr), |((m_rise | m_fall) & m_en));
            end
        end
        @(negedge clk) en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_debounce_edge();
        test_glitch();
        test_irq();
        test_set_wins();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
